// File: rtl/jh_external_burst_framer.sv
`default_nettype none
// ============================================================================
// Module : jh_external_burst_framer
// Drains the external-SRAM FIFO as sop/eop framed bursts of BURST_LEN words,
// flushing a short burst once fewer words have waited TIMEOUT cycles.
// Rev    : 1.0
// ============================================================================
module jh_external_burst_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 256,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 64,
    localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
    localparam int LB_BURST      = $clog2(BURST_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   fifo_data,
    input  logic                    fifo_valid,
    output logic                    fifo_ready,
    input  logic [LB_FIFO_DEPTH:0]  fifo_count,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sop,
    output logic                    m_eop,
    output logic [LB_BURST-1:0]     m_len,
    output logic                    busy
);

    localparam int CNT_W    = LB_FIFO_DEPTH + 1;
    localparam int WAIT_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]    C_BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [LB_BURST-1:0] C_BURST_LEN  = LB_BURST'(BURST_LEN);
    localparam logic [LB_BURST-1:0] C_ONE        = LB_BURST'(1);
    localparam logic [WAIT_W-1:0]   C_WAIT_MAX   = WAIT_W'(WAIT_MAX);
    localparam logic                C_TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LB_BURST-1:0] r_len;
    logic [LB_BURST-1:0] w_len_nxt;
    logic [LB_BURST-1:0] r_remain;
    logic [LB_BURST-1:0] w_remain_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_fetch;

    assign fifo_ready = (r_state == ST_BURST) && (!m_valid || m_ready);
    assign w_fetch    = fifo_valid && fifo_ready;
    assign busy       = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_remain_nxt = r_remain;
        w_wait_nxt   = r_wait;
        case (r_state)
            ST_IDLE: begin
                if (fifo_count >= C_BURST_CNT) begin
                    w_state_nxt  = ST_BURST;
                    w_len_nxt    = C_BURST_LEN;
                    w_remain_nxt = C_BURST_LEN;
                    w_wait_nxt   = '0;
                end else if (C_TIMEOUT_EN && (fifo_count != '0) && (r_wait == C_WAIT_MAX)) begin
                    // count is below BURST_LEN here, so the low bits hold it exactly
                    w_state_nxt  = ST_BURST;
                    w_len_nxt    = fifo_count[LB_BURST-1:0];
                    w_remain_nxt = fifo_count[LB_BURST-1:0];
                    w_wait_nxt   = '0;
                end else if (fifo_count == '0) begin
                    w_wait_nxt = '0;
                end else if (r_wait != C_WAIT_MAX) begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_BURST: begin
                w_wait_nxt = '0;
                if (w_fetch) begin
                    w_remain_nxt = r_remain - C_ONE;
                    if (r_remain == C_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (clear) begin
            w_state_nxt  = ST_IDLE;
            w_len_nxt    = '0;
            w_remain_nxt = '0;
            w_wait_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_remain <= '0;
            r_wait   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_remain <= w_remain_nxt;
            r_wait   <= w_wait_nxt;
        end
    end

    // The first fetch of a burst is the one that sees remain still equal to len.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_len   <= '0;
        end else if (clear) begin
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else if (w_fetch) begin
            m_data  <= fifo_data;
            m_valid <= 1'b1;
            m_sop   <= (r_remain == r_len);
            m_eop   <= (r_remain == C_ONE);
            m_len   <= r_len;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jh_external_burst_framer.sv
`default_nettype none
// ============================================================================
// Module : tb_jh_external_burst_framer
// Directed bench: FIFO model feeding the framer, output log checked per test.
// Rev    : 1.0
// ============================================================================
module tb_jh_external_burst_framer;

    localparam int DW = 8;
    localparam int FD = 16;
    localparam int BL = 4;
    localparam int TO = 8;
    localparam int CW = $clog2(FD) + 1;
    localparam int LW = $clog2(BL + 1);

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] fifo_data;
    logic          fifo_valid;
    logic          fifo_ready;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sop;
    logic          m_eop;
    logic [LW-1:0] m_len;
    logic          busy;

    logic [DW-1:0] fifo_data0  = '0;
    logic          fifo_valid0 = 1'b0;
    logic [CW-1:0] fifo_count0 = '0;
    logic          fifo_ready0;
    logic [DW-1:0] m_data0;
    logic          m_valid0;
    logic          m_sop0;
    logic          m_eop0;
    logic [LW-1:0] m_len0;
    logic          busy0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    jh_external_burst_framer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BURST_LEN(BL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .fifo_count(fifo_count),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_len(m_len), .busy(busy)
    );

    jh_external_burst_framer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BURST_LEN(BL), .TIMEOUT(0)
    ) dut0 (
        .clk(clk), .rstn(rstn), .clear(clear),
        .fifo_data(fifo_data0), .fifo_valid(fifo_valid0), .fifo_ready(fifo_ready0),
        .fifo_count(fifo_count0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(1'b1),
        .m_sop(m_sop0), .m_eop(m_eop0), .m_len(m_len0), .busy(busy0)
    );

    // FIFO model: words staged by push() enter on the next edge; pop on fetch.
    logic [DW-1:0] src_mem [0:63];
    int            src_wr = 0;
    int            src_rd = 0;
    logic [DW-1:0] fmem [0:63];
    int            fr = 0;
    int            fw = 0;

    assign fifo_count = CW'(fw - fr);
    assign fifo_valid = (fw != fr);
    assign fifo_data  = fmem[fr % 64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn || clear) begin
            fr     <= fw;
            src_rd <= src_wr;
        end else begin
            if (fifo_ready && fifo_valid) fr <= fr + 1;
            for (int i = 0; i < src_wr - src_rd; i++) fmem[(fw + i) % 64] <= src_mem[(src_rd + i) % 64];
            fw     <= fw + (src_wr - src_rd);
            src_rd <= src_wr;
        end
    end

    logic [DW-1:0] lg_data [0:127];
    logic          lg_sop  [0:127];
    logic          lg_eop  [0:127];
    logic [LW-1:0] lg_len  [0:127];
    int            lg_cyc  [0:127];
    int            lg_n = 0;

    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            lg_data[lg_n % 128] <= m_data;
            lg_sop[lg_n % 128]  <= m_sop;
            lg_eop[lg_n % 128]  <= m_eop;
            lg_len[lg_n % 128]  <= m_len;
            lg_cyc[lg_n % 128]  <= cyc;
            lg_n                <= lg_n + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) src_mem[(src_wr + i) % 64] = base + DW'(i);
        src_wr = src_wr + n;
    endtask

    task automatic wait_log(input int target);
        for (int k = 0; k < 60 && lg_n < target; k++) step(1);
        step(3);
    endtask

    function automatic string wstr(input int i);
        return $sformatf("data=%h sop=%b eop=%b len=%0d cyc=%0d",
                         lg_data[i % 128], lg_sop[i % 128], lg_eop[i % 128], lg_len[i % 128], lg_cyc[i % 128]);
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        step(2);
        n_tests++;
        if ({fifo_ready, m_valid, m_data, m_sop, m_eop, m_len, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b v=%b d=%h sop=%b eop=%b len=%0d busy=%b, expected all 0",
                     fifo_ready, m_valid, m_data, m_sop, m_eop, m_len, busy);
        end
        rstn = 1'b1;
        step(2);
        n_tests++;
        if ({busy, fifo_ready, m_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rdy=%b v=%b, expected 000", busy, fifo_ready, m_valid);
        end
    endtask

    task automatic test_full_burst();
        int s, n;
        m_ready = 1'b1;
        s = lg_n;
        n = cyc + 1;
        push(8'h10, 4);
        wait_log(s + 4);
        n_tests++;
        if (lg_n - s !== 4) begin
            n_fail++;
            $display("FAIL full_count: got %0d words, expected 4", lg_n - s);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (lg_data[s+i] !== 8'h10 + DW'(i) || lg_sop[s+i] !== (i == 0) || lg_eop[s+i] !== (i == 3) ||
                lg_len[s+i] !== LW'(4) || lg_cyc[s+i] !== n + 2 + i) begin
                n_fail++;
                $display("FAIL full_word%0d: got %s, expected data=%h sop=%b eop=%b len=4 cyc=%0d",
                         i, wstr(s + i), 8'h10 + DW'(i), (i == 0), (i == 3), n + 2 + i);
            end
        end
    endtask

    task automatic test_timeout();
        int s, n, bad, bad0;
        m_ready     = 1'b1;
        s           = lg_n;
        n           = cyc + 1;
        bad         = 0;
        bad0        = 0;
        fifo_count0 = CW'(2);
        fifo_valid0 = 1'b1;
        fifo_data0  = 8'h55;
        push(8'hA0, 2);
        step(1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fifo_ready || busy) bad++;
            step(1);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_idle: %0d early busy/fetch cycles, expected 0", bad);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_enter: busy=%b at cycle N+8, expected 1", busy);
        end
        wait_log(s + 2);
        n_tests++;
        if (lg_n - s !== 2) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d words, expected 2", lg_n - s);
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (lg_data[s+i] !== 8'hA0 + DW'(i) || lg_sop[s+i] !== (i == 0) || lg_eop[s+i] !== (i == 1) ||
                lg_len[s+i] !== LW'(2) || lg_cyc[s+i] !== n + 9 + i) begin
                n_fail++;
                $display("FAIL timeout_word%0d: got %s, expected data=%h sop=%b eop=%b len=2 cyc=%0d",
                         i, wstr(s + i), 8'hA0 + DW'(i), (i == 0), (i == 1), n + 9 + i);
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_valid0 || busy0 || fifo_ready0) bad0++;
            step(1);
        end
        n_tests++;
        if (bad0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_disabled: %0d active cycles with TIMEOUT=0, expected 0", bad0);
        end
        fifo_count0 = '0;
        fifo_valid0 = 1'b0;
    endtask

    task automatic test_backpressure();
        int s, n;
        m_ready = 1'b1;
        s = lg_n;
        n = cyc + 1;
        push(8'h10, 4);
        step(4);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== 8'h11 || fifo_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%b data=%h rdy=%b, expected v=1 data=11 rdy=0",
                         k, m_valid, m_data, fifo_ready);
            end
            step(1);
        end
        m_ready = 1'b1;
        wait_log(s + 4);
        n_tests++;
        if (lg_n - s !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, expected 4", lg_n - s);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (lg_data[s+i] !== 8'h10 + DW'(i) || lg_sop[s+i] !== (i == 0) || lg_eop[s+i] !== (i == 3) ||
                lg_cyc[s+i] !== ((i == 0) ? n + 2 : n + 7 + i)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %s, expected data=%h sop=%b eop=%b cyc=%0d",
                         i, wstr(s + i), 8'h10 + DW'(i), (i == 0), (i == 3), (i == 0) ? n + 2 : n + 7 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s, n, ec;
        m_ready = 1'b1;
        s = lg_n;
        n = cyc + 1;
        push(8'h30, 8);
        wait_log(s + 8);
        n_tests++;
        if (lg_n - s !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words, expected 8", lg_n - s);
        end
        for (int i = 0; i < 8; i++) begin
            ec = (i < 4) ? n + 2 + i : n + 3 + i;
            n_tests++;
            if (lg_data[s+i] !== 8'h30 + DW'(i) || lg_sop[s+i] !== (i % 4 == 0) ||
                lg_eop[s+i] !== (i % 4 == 3) || lg_len[s+i] !== LW'(4) || lg_cyc[s+i] !== ec) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %s, expected data=%h sop=%b eop=%b len=4 cyc=%0d",
                         i, wstr(s + i), 8'h30 + DW'(i), (i % 4 == 0), (i % 4 == 3), ec);
            end
        end
        n_tests++;
        if (lg_cyc[s+4] - lg_cyc[s+3] !== 2) begin
            n_fail++;
            $display("FAIL b2b_gap: gap %0d cycles between bursts, expected 2", lg_cyc[s+4] - lg_cyc[s+3]);
        end
    endtask

    task automatic test_clear();
        int s;
        m_ready = 1'b1;
        s = lg_n;
        push(8'h40, 4);
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({m_valid, busy, fifo_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL clear_outputs: v=%b busy=%b rdy=%b, expected 000", m_valid, busy, fifo_ready);
        end
        step(15);
        n_tests++;
        if (lg_n - s !== 1 || lg_data[s] !== 8'h40 || lg_sop[s] !== 1'b1 || lg_eop[s] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_abandon: %0d words, first %s, expected 1 word data=40 sop=1 eop=0",
                     lg_n - s, wstr(s));
        end
        s = lg_n;
        push(8'h50, 4);
        wait_log(s + 4);
        n_tests++;
        if (lg_n - s !== 4 || lg_data[s] !== 8'h50 || lg_sop[s] !== 1'b1 ||
            lg_data[s+3] !== 8'h53 || lg_eop[s+3] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_restart: %0d words, first %s last %s, expected 4 words 50(sop)..53(eop)",
                     lg_n - s, wstr(s), wstr(s + 3));
        end
    endtask

    task automatic test_reset_mid();
        int s;
        m_ready = 1'b0;
        s = lg_n;
        push(8'h60, 4);
        step(5);
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h60) begin
            n_fail++;
            $display("FAIL rst_mid_pre: v=%b data=%h, expected v=1 data=60", m_valid, m_data);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({fifo_ready, m_valid, m_data, m_sop, m_eop, m_len, busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: rdy=%b v=%b d=%h sop=%b eop=%b len=%0d busy=%b, expected all 0",
                     fifo_ready, m_valid, m_data, m_sop, m_eop, m_len, busy);
        end
        step(2);
        rstn    = 1'b1;
        m_ready = 1'b1;
        step(1);
        @(negedge clk);
        n_tests++;
        if ({busy, fifo_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_idle: busy=%b rdy=%b, expected 00", busy, fifo_ready);
        end
        step(15);
        n_tests++;
        if (lg_n - s !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: %0d words after reset, expected 0", lg_n - s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jh_external_burst_framer.md
# jh_external_burst_framer

Downstream consumer of the external-SRAM synchronous FIFO. Watches the FIFO occupancy `count`, then drains stored words as framed bursts of `BURST_LEN` words, marked with start-of-packet and end-of-packet. When fewer than `BURST_LEN` words have been waiting for `TIMEOUT` cycles, it flushes them as one short burst. Output is a registered valid/ready stream for the next stage (DMA / link packetizer).

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width; must equal the FIFO's.
- `FIFO_DEPTH`, 256: FIFO capacity; sizes `fifo_count`.
- `BURST_LEN`, 16: full burst length, 1..FIFO_DEPTH.
- `TIMEOUT`, 64: idle cycles before a short-burst flush; 0 disables flushing.
- `LB_FIFO_DEPTH` (localparam): `$clog2(FIFO_DEPTH)`.
- `LB_BURST` (localparam): `$clog2(BURST_LEN+1)`.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous flush; driven from the same source as the FIFO's `clear`.
- `fifo_data`  in  DATA_WIDTH  FIFO `out_data`.
- `fifo_valid`  in  1  FIFO `out_valid`.
- `fifo_ready`  out  1  drives FIFO `out_ready`.
- `fifo_count`  in  LB_FIFO_DEPTH+1  FIFO `count`.
- `m_data`  out  DATA_WIDTH  output word (registered).
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  output ready.
- `m_sop`  out  1  first word of a burst.
- `m_eop`  out  1  last word of a burst.
- `m_len`  out  LB_BURST  length of the current burst; constant for every word of that burst.
- `busy`  out  1  high while the state is not IDLE.

## Operation
- **State machine: IDLE, BURST.**
- **IDLE**
  - If `fifo_count >= BURST_LEN`: set `len_r = BURST_LEN`, move to BURST.
  - Else if `TIMEOUT != 0`, `fifo_count > 0`, and `wait_cnt == TIMEOUT-1`: set `len_r = fifo_count` (always < BURST_LEN), move to BURST.
- **`wait_cnt`**
  - Increments each IDLE cycle with `0 < fifo_count < BURST_LEN`.
  - Cleared when `fifo_count == 0`, when leaving IDLE, and while in BURST.
  - Saturates at `TIMEOUT-1`.
- **BURST**
  - `remain_r` loads `len_r` on entry.
  - Fetch: `fifo_valid & fifo_ready`. Each fetch decrements `remain_r`.
  - The first fetch of a burst tags the word sop; the fetch with `remain_r == 1` tags it eop and returns to IDLE.
- **`fifo_ready`** = (state == BURST) & (`!m_valid | m_ready`). It is never asserted in IDLE.
- **Output register**
  - On a fetch, load `m_data`/`m_sop`/`m_eop`/`m_len` and set `m_valid`.
  - On `m_valid & m_ready` with no fetch, clear `m_valid`.
  - While `m_valid & !m_ready`, all `m_*` hold stable.
- **Burst lengths**
  - `fifo_count` guarantees that `len_r` words exist, so a burst never truncates.
  - Gaps in `fifo_valid` (prefetch latency) only stall the burst.
- **Arithmetic:** compare `fifo_count` zero-extended to the wider width; no wrap is possible since `remain_r <= BURST_LEN`.
- **Clear**
  - Next state is IDLE.
  - `m_valid`, `m_sop`, `m_eop` go to 0; `wait_cnt`, `remain_r`, `len_r` go to 0.
  - `clear` overrides any fetch in the same cycle.
  - A partially sent burst is abandoned without an eop.

## Timing
- **Reset values:** `fifo_ready`=0, `m_valid`=0, `m_data`=0, `m_sop`=0, `m_eop`=0, `m_len`=0, `busy`=0; state IDLE; all counters 0.
- **Decision latency:** `fifo_count` reaches `BURST_LEN` in cycle N → state BURST and `fifo_ready` high in N+1 → first word on `m_*` in N+2 (if `fifo_valid` is high in N+1).
- **Throughput:** 1 word/cycle with `fifo_valid` and `m_ready` continuously high.
- **Inter-burst gap:** the cycle after the eop fetch is always IDLE, so there is at least one idle fetch cycle between bursts.
- **Timeout:** with a constant nonzero count < BURST_LEN from cycle N, the flush decision happens in cycle N+TIMEOUT-1 and BURST is entered in N+TIMEOUT.
- **Single-word bursts** (`len_r == 1`): `m_sop` and `m_eop` are both high on the same word.
- **`busy`** is combinational from state.

## Test plan
1. **Reset:** assert `rstn=0` mid-burst → all outputs 0 asynchronously; after release, state IDLE and `fifo_ready=0`.
2. **Full burst** (BURST_LEN=4, TIMEOUT=0, `m_ready=1`): count 4, words 0x10..0x13 → `m_data` 0x10..0x13 on consecutive cycles, sop on 0x10, eop on 0x13, `m_len=4`, first word two cycles after count hits 4.
3. **Timeout flush** (BURST_LEN=4, TIMEOUT=8): push 2 words 0xA0, 0xA1 → no fetch for 7 cycles, BURST entered on the 8th, burst of 2 with `m_len=2`, sop on 0xA0, eop on 0xA1; with TIMEOUT=0 nothing is emitted.
4. **Backpressure:** during a 4-word burst hold `m_ready=0` for 5 cycles after word 2 → `m_data` stays 0x11 stable, `fifo_ready=0`, no drop or duplicate; resume delivers 0x12, 0x13 with eop.
5. **Back-to-back:** 8 words with BURST_LEN=4 → two bursts, sop/eop on words 0/3 and 4/7, exactly one idle fetch cycle between them.
6. **Clear mid-burst:** `clear=1` after word 1 of 4 → next cycle `m_valid=0`, `busy=0`, no eop emitted; with the FIFO also cleared, no burst starts until new words arrive.
